// File: rtl/titan_pkg.sv
// titan_pkg: definitions shared by the instruction-fetch unit.
//   NOP_INST_DEF - word substituted for a bus-error fetch when FETCHQ_ERR_EN
//                  is not defined (addi x0, x0, 0).
//   fq_state_e   - fetch FSM states (HALT is only entered with FETCHQ_ERR_EN).
//   fq_entry_t   - one queue entry, laid out as {err, pc[31:0], inst[31:0]}.
package titan_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fq_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// fetchq_fifo: DEPTH x 65-bit synchronous FIFO holding fetched entries.
// Ports:
//   clk, rst        clock, asynchronous active-low reset of the pointers
//   flush_i         empty the FIFO this edge (wins over push/pop)
//   push_i/data_i   write one entry (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   head_o          entry at the head (stale when empty_o; caller masks it)
//   count_o         number of stored entries, 0..DEPTH
//   full_o/empty_o  occupancy flags
module fetchq_fifo
  import titan_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fq_entry_t              data_i,
  input  logic                   pop_i,
  output fq_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // One extra pointer bit distinguishes full from empty.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  fq_entry_t mem_q [DEPTH];

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == PW'(DEPTH));
  assign empty_o = (count_o == '0);

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
          mem_q[gi] <= data_i;
        end
      end
    end
  endgenerate

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch unit with a DEPTH-entry prefetch queue.
// Owns the fetch PC, issues single-outstanding Wishbone reads and hands
// {inst, pc, err} to decode through a valid/ready handshake. A redirect
// flushes the queue, squashes any in-flight response and restarts fetch.
// Optional feature macro: FETCHQ_ERR_EN
//   defined   - a bus error pushes an error entry and halts fetch until redirect
//   undefined - a bus error is treated as an ack carrying NOP_INST; err_o = 0
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   redirect_i, redirect_pc_i  flush and restart at redirect_pc_i (bits 1:0 ignored)
//   inst_o, pc_o, err_o        head entry (zero when the queue is empty)
//   valid_o, ready_i           decode handshake
//   iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o   Wishbone master (read only)
//   idat_i, iack_i, ierr_i     Wishbone response
module fetch_queue
  import titan_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = titan_pkg::NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        err_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] iaddr_o,
  output logic [31:0] idat_o,
  output logic [3:0]  isel_o,
  output logic        icyc_o,
  output logic        istb_o,
  output logic        iwe_o,
  input  logic [31:0] idat_i,
  input  logic        iack_i,
  input  logic        ierr_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] iaddr_q, iaddr_d;

  logic          push;
  fq_entry_t     push_entry;
  fq_entry_t     head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          pop_req;
  logic          bus_resp;
  logic          room_after_push;

  assign bus_resp = iack_i || ierr_i;
  assign pop_req  = valid_o && ready_i;

  // A request is only in flight while its slot is reserved, so after its own
  // push another slot exists if a pop frees one this edge or the queue will
  // still be short of full.
  assign room_after_push = pop_req || (fifo_count < CW'(DEPTH - 1));

  fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop_req),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      iaddr_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      iaddr_q    <= iaddr_d;
    end
  end

  // Next state, fetch PC and queue push
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    iaddr_d    = iaddr_q;
    push       = 1'b0;
    push_entry = '0;

    unique case (state_q)
      // Nothing is outstanding in IDLE, so the slot reservation reduces to
      // "queue not full".
      IDLE: begin
        if (!redirect_i && !fifo_full) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_i) begin
          // A same-cycle response is simply dropped; otherwise wait it out.
          state_d = bus_resp ? IDLE : DRAIN;
        end else if (bus_resp) begin
          push          = 1'b1;
          push_entry.pc = fetch_pc_q;
`ifdef FETCHQ_ERR_EN
          if (ierr_i) begin
            push_entry.err  = 1'b1;
            push_entry.inst = '0;
            state_d         = HALT;
          end else begin
            push_entry.inst = idat_i;
            fetch_pc_d      = fetch_pc_q + 32'd4;
            state_d         = room_after_push ? REQ : IDLE;
          end
`else
          push_entry.inst = ierr_i ? NOP_INST : idat_i;
          fetch_pc_d      = fetch_pc_q + 32'd4;
          state_d         = room_after_push ? REQ : IDLE;
`endif
        end
      end
      DRAIN: begin
        if (bus_resp) begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (redirect_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
    end

    // Latch the bus address only when a new request starts so it stays
    // stable for the whole cycle, including a squashed one in DRAIN.
    if ((state_d == REQ) && ((state_q != REQ) || bus_resp)) begin
      iaddr_d = fetch_pc_d;
    end
  end

  // Outputs. icyc/istb follow state_q, which clears asynchronously on reset.
  always_comb begin
    icyc_o  = (state_q == REQ) || (state_q == DRAIN);
    istb_o  = (state_q == REQ) || (state_q == DRAIN);
    iaddr_o = iaddr_q;
    valid_o = !fifo_empty;
    inst_o  = fifo_empty ? '0 : head.inst;
    pc_o    = fifo_empty ? '0 : head.pc;
`ifdef FETCHQ_ERR_EN
    err_o   = !fifo_empty && head.err;
`else
    err_o   = 1'b0;
`endif
  end

`ifndef FETCHQ_ERR_EN
  logic unused_head_err;
  assign unused_head_err = head.err;
`endif

  assign idat_o = '0;
  assign isel_o = 4'b1111;
  assign iwe_o  = 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_o, pc_o;
  logic        err_o, valid_o, ready_i;
  logic [31:0] iaddr_o, idat_o;
  logic [3:0]  isel_o;
  logic        icyc_o, istb_o, iwe_o;
  logic [31:0] idat_i;
  logic        iack_i, ierr_i;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .err_o         (err_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .iaddr_o       (iaddr_o),
    .idat_o        (idat_o),
    .isel_o        (isel_o),
    .icyc_o        (icyc_o),
    .istb_o        (istb_o),
    .iwe_o         (iwe_o),
    .idat_i        (idat_i),
    .iack_i        (iack_i),
    .ierr_i        (ierr_i)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stimulus knobs
  int          ready_mode;     // 0 never, 1 always, 2 random
  int          wait_max;
  logic        stall_en;
  logic [31:0] stall_addr;
  int          stall_cycles;
  logic        err_one_en;
  logic [31:0] err_one_addr;
  logic        err_rand_en;
  logic        redir_req;
  logic [31:0] redir_tgt;

  // Slave state
  logic        in_req, squashed;
  logic [31:0] req_addr;
  int          wait_left;

  // Reference model: stream of expected PCs and queue occupancy
  int          occ;
  logic [31:0] exp_pc;
  int          acks_total, pops_total;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return (err_one_en && a == err_one_addr) || (err_rand_en && a[6:2] == 5'h13);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
`ifdef FETCHQ_ERR_EN
    return is_err(a) ? 32'h0 : mem_word(a);
`else
    return is_err(a) ? NOP : mem_word(a);
`endif
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
`ifdef FETCHQ_ERR_EN
    return is_err(a);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs at negedge, check, advance model past posedge.
  task automatic step();
    logic resp, popping;
    resp = 1'b0;
    iack_i = 1'b0; ierr_i = 1'b0; idat_i = 32'h0;
    if (icyc_o && istb_o) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_addr = iaddr_o;
        if (stall_en && iaddr_o == stall_addr) begin
          wait_left = stall_cycles;
          stall_en  = 1'b0;
        end else begin
          wait_left = (wait_max == 0) ? 0 : $urandom_range(wait_max, 0);
        end
        if (!squashed) check("reserve", occ < DEPTH, 1);
      end else begin
        check("addr_stable", iaddr_o, req_addr);
      end
      if (wait_left == 0) begin
        resp = 1'b1;
        if (is_err(req_addr)) ierr_i = 1'b1;
        else begin
          iack_i = 1'b1;
          idat_i = mem_word(req_addr);
        end
      end else begin
        wait_left--;
      end
    end
    case (ready_mode)
      0:       ready_i = 1'b0;
      1:       ready_i = 1'b1;
      default: ready_i = 1'($urandom_range(1, 0));
    endcase
    redirect_i    = redir_req;
    redirect_pc_i = redir_req ? redir_tgt : $urandom;
    redir_req     = 1'b0;

    check("valid", valid_o, occ > 0);
    popping = valid_o && ready_i && !redirect_i;
    if (popping) begin
      $display("pop pc=%h inst=%h err=%b", pc_o, inst_o, err_o);
      check("pc", pc_o, exp_pc);
      check("inst", inst_o, exp_inst(exp_pc));
      check("err", err_o, exp_err(exp_pc));
    end
    if (redirect_i) $display("redirect to %h", redirect_pc_i);

    @(posedge clk);
    if (redirect_i) begin
      occ    = 0;
      exp_pc = redirect_pc_i & ~32'h3;
      if (in_req && !resp) squashed = 1'b1;
    end else begin
      if (resp && !squashed) begin
        occ++;
        acks_total++;
      end
      if (popping) begin
        occ--;
        exp_pc = exp_pc + 32'd4;
        pops_total++;
      end
    end
    if (resp) begin
      in_req   = 1'b0;
      squashed = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    iack_i = 1'b0; ierr_i = 1'b0; idat_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; ready_i = 1'b0;
    in_req = 1'b0; squashed = 1'b0; occ = 0; exp_pc = 32'h0;
    acks_total = 0; pops_total = 0; redir_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_cyc", icyc_o, 0);
    check("rst_stb", istb_o, 0);
    check("rst_addr", iaddr_o, 32'h0);
    check("rst_const", {idat_o[27:0], isel_o, iwe_o}, {28'h0, 4'hF, 1'b0});
    rst = 1'b1;
  endtask

  task automatic wait_for_valid(input string tag, input int limit);
    int n = 0;
    while (!valid_o && n < limit) begin
      step();
      n++;
    end
    check(tag, valid_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ready_mode = 1; wait_max = 0; stall_en = 1'b0; stall_addr = 32'h0; stall_cycles = 0;
    err_one_en = 1'b0; err_one_addr = 32'h0; err_rand_en = 1'b0;
    redir_req = 1'b0; redir_tgt = 32'h0; wait_left = 0; req_addr = 32'h0;
    @(negedge clk);

    // Streaming from reset with a zero-wait slave
    do_reset();
    step();
    check("first_req_cyc", icyc_o, 1);
    check("first_req_addr", iaddr_o, 32'h0);
    repeat (10) step();
    check("stream_pops", pops_total, 9);

    // Decode stalled: exactly DEPTH requests, then resume in order
    ready_mode = 0;
    do_reset();
    repeat (12) step();
    check("fill_acks", acks_total, DEPTH);
    check("fill_cyc", icyc_o, 0);
    check("fill_valid", valid_o, 1);
    ready_mode = 1;
    repeat (10) step();
    check("fill_resume", pops_total > 4, 1);

    // Redirect while the request to 0x8 is stalled
    do_reset();
    stall_en = 1'b1; stall_addr = 32'h8; stall_cycles = 5;
    for (int i = 0; i < 20 && !(icyc_o && iaddr_o == 32'h8); i++) step();
    check("stall_reach", icyc_o && iaddr_o == 32'h8, 1);
    repeat (3) step();
    redir_req = 1'b1; redir_tgt = 32'h200;
    step();
    wait_for_valid("stall_valid", 30);
    check("stall_redir_pc", pc_o, 32'h200);
    repeat (5) step();

    // Redirect coincident with ack and pop
    do_reset();
    repeat (6) step();
    check("coinc_pre", valid_o && icyc_o, 1);
    redir_req = 1'b1; redir_tgt = 32'h300;
    step();
    check("coinc_empty", valid_o, 0);
    check("coinc_idle", icyc_o, 0);
    step();
    check("coinc_req", icyc_o, 1);
    check("coinc_addr", iaddr_o, 32'h300);
    wait_for_valid("coinc_valid", 10);
    check("coinc_pc", pc_o, 32'h300);

    // Bus error on 0xC
    err_one_addr = 32'hC;
    err_one_en   = 1'b1;
    do_reset();
    repeat (8) step();
`ifdef FETCHQ_ERR_EN
    check("err_pops", pops_total, 4);
    repeat (4) begin
      step();
      check("err_halt_cyc", icyc_o, 0);
    end
    redir_req = 1'b1; redir_tgt = 32'h40;
    step();
    wait_for_valid("err_restart", 10);
    check("err_restart_pc", pc_o, 32'h40);
`else
    check("err_pops", pops_total, 6);
`endif
    repeat (4) step();
    err_one_en = 1'b0;

    // Redirect to the top of the address space wraps to 0
    do_reset();
    redir_req = 1'b1; redir_tgt = 32'hFFFF_FFFF;
    step();
    wait_for_valid("wrap_valid0", 10);
    check("wrap_pc0", pc_o, 32'hFFFF_FFFC);
    step();
    wait_for_valid("wrap_valid1", 10);
    check("wrap_pc1", pc_o, 32'h0);

    // Reset in the middle of a request
    do_reset();
    stall_en = 1'b1; stall_addr = 32'h0; stall_cycles = 6;
    step();
    check("mid_pre_cyc", icyc_o, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cyc", icyc_o, 0);
    check("mid_rst_stb", istb_o, 0);
    iack_i = 1'b1; idat_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", valid_o, 0);
    stall_en = 1'b0;

    // Randomised traffic
`ifndef FETCHQ_ERR_EN
    err_rand_en = 1'b1;
`endif
    ready_mode = 2;
    wait_max   = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49, 0) == 0) begin
        redir_req = 1'b1;
        redir_tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                                : $urandom_range(32'hFFF, 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
